lz77_decoder: RTL and testbench
===============================

Name: lz77_decoder

Overview:
- Reconstructs the original character stream from LZ77 code triplets (offset, match_len, char_nxt) produced by the team's LZ77 encoder.
- Keeps a 9-character search (history) buffer and copies match_len characters out of it, one per cycle.
- Then emits the literal char_nxt.
- Sits at the receive end of the compression link: triplets come in from the stream or testbench, and decoded bytes go out to the image sink.

Parameters:
- SEARCH_LEN, 9: history depth in chars; offset 0 is the newest char.
- CHAR_W, 8: character width.
- OFF_W, 4: offset field width.
- LEN_W, 3: match_len field width (0-7).
- END_CHAR, 8'h24: end-of-stream literal ('$').

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- code_valid  in  1  triplet present on code_* this cycle
- code_ready  out  1  decoder accepts a triplet this cycle
- code_offset  in  4  match offset, 0..8 (0 = most recent char)
- code_len  in  3  match length, 0..7
- code_char  in  8  literal following the match
- char_valid  out  1  char_out holds a decoded char this cycle
- char_out  out  8  decoded character
- finish  out  1  end-of-stream seen; held until reset
- encode  out  1  constant 0 (mode flag; the encoder drives 1)

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All 9 history entries are set to END_CHAR.
  - char_valid=0, char_out=0, finish=0; code_ready=1 after reset is released.
  - Reset asserted mid-operation aborts the current triplet; no further chars are emitted.
- All outputs except code_ready and encode are registered. code_ready is decoded from state.
- Handshake: a triplet is accepted on the rising edge where code_valid && code_ready. Fields are latched into off_r, len_r, lit_r, and a copy counter cnt is cleared.
- States:
  - IDLE: code_ready=1. On accept: go to COPY if code_len!=0, else go to LIT.
  - COPY: each cycle, char_out<=hist[SEARCH_LEN-1-off_r], char_valid<=1, the same char is shifted into the history, and cnt++. When cnt==len_r-1, go to LIT.
  - LIT:
    - If lit_r==END_CHAR: char_valid<=0, finish<=1, go to DONE. The '$' is never emitted as data.
    - Otherwise: char_out<=lit_r, char_valid<=1, lit_r is shifted into history, go to IDLE.
  - DONE: code_ready=0, char_valid=0, finish=1. Only reset leaves DONE.
- History shift: hist[i]<=hist[i+1] for i=0..7; hist[8]<=new char. At most one shift per cycle.
- Overlapping copies (len_r > off_r+1) are legal. Because the read index is fixed and the buffer shifts each cycle, the copy reproduces the periodic pattern.
- Latency and throughput:
  - The first output char is valid in the cycle after the accept edge.
  - A triplet yields len+1 consecutive char_valid cycles.
  - The next accept is possible in the cycle after LIT, so each triplet takes len+2 cycles.
- char_valid is high for exactly one cycle per char; there is no output backpressure.
- code_offset values 9..15 saturate to 8. code_* inputs are ignored when code_ready=0.
- A LIT cycle with a non-'$' literal leaves finish at 0. No other path sets finish.

Decomposition:
- Package lz77_pkg:
  - SEARCH_LEN, CHAR_W, OFF_W, LEN_W, END_CHAR
  - state encoding IDLE/COPY/LIT/DONE
  - shared with the encoder so both sides agree on widths and the end symbol.
- One sub-module, lz77_hist_buf:
  - 9-entry shift register with async reset to END_CHAR
  - one shift-in port plus shift enable
  - one combinational read port indexed by offset.
- The top level holds the FSM, field latches, counter and output registers.

Test Plan:
1. Reset pulse mid-stream -> code_ready=1, char_valid=0, finish=0 immediately. Then (0,3,'Z') -> 0x24,0x24,0x24,0x5A on 4 consecutive cycles.
2. From reset, (0,0,'A') then (0,0,'B') -> char_out 0x41, then 0x42 two cycles later. code_ready is low only during each LIT cycle.
3. After "AB", send (1,2,'C') -> outputs 'A','B','C'; the full stream is "ABABC".
4. After 'A', send overlap (0,5,'X') -> 'A'×5 then 'X'. Also check code_offset=15 behaves exactly like offset 8.
5. Send (2,1,'$') after "XYZ" -> one char 'X' on char_valid. The next cycle has char_valid=0 and finish=1. code_ready stays 0, and further triplets are ignored.
6. Assert reset during COPY of (0,7,'Q') -> no more char_valid, finish=0, history back to '$'. The next triplet (0,1,'R') -> 0x24,0x52.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared LZ77 constants: widths, history depth, end-of-stream symbol and FSM encoding.
// Used by both encoder and decoder so the two ends of the link agree.
package lz77_pkg;

   localparam int SEARCH_LEN = 9;
   localparam int CHAR_W     = 8;
   localparam int OFF_W      = 4;
   localparam int LEN_W      = 3;

   localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_COPY = 2'd1;
   localparam logic [1:0] ST_LIT  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Offsets beyond the oldest history entry clamp to the oldest entry.
   function automatic logic [OFF_W-1:0] sat_offset(input logic [OFF_W-1:0] off);
      if (off > OFF_W'(SEARCH_LEN - 1)) begin
         return OFF_W'(SEARCH_LEN - 1);
      end else begin
         return off;
      end
   endfunction

endpackage

// File: rtl/lz77_hist_buf.sv
// Search-history shift register: newest char enters at the top entry, oldest falls out of entry 0.
// Read port is addressed by match offset (0 = newest char).
module lz77_hist_buf
   import lz77_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en_i,
   input  logic [CHAR_W-1:0] shift_data_i,
   input  logic [OFF_W-1:0]  rd_off_i,
   output logic [CHAR_W-1:0] rd_data_o
);

   logic [CHAR_W-1:0] hist_q [SEARCH_LEN];
   logic [OFF_W-1:0]  rd_idx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SEARCH_LEN; i++) begin
            hist_q[i] <= END_CHAR;
         end
      end else if (shift_en_i) begin
         for (int i = 0; i < SEARCH_LEN - 1; i++) begin
            hist_q[i] <= hist_q[i+1];
         end
         hist_q[SEARCH_LEN-1] <= shift_data_i;
      end
   end

   assign rd_idx_s  = OFF_W'(SEARCH_LEN - 1) - rd_off_i;
   assign rd_data_o = hist_q[rd_idx_s];

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 triplet decoder: copies match_len chars from a 9-char history, then emits the literal.
// A '$' literal ends the stream and parks the decoder in DONE until reset.
module lz77_decoder
   import lz77_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              code_valid,
   output logic              code_ready,
   input  logic [OFF_W-1:0]  code_offset,
   input  logic [LEN_W-1:0]  code_len,
   input  logic [CHAR_W-1:0] code_char,
   output logic              char_valid,
   output logic [CHAR_W-1:0] char_out,
   output logic              finish,
   output logic              encode
);

   logic [1:0]        state_q, state_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [CHAR_W-1:0] lit_q, lit_d;
   logic              char_valid_q, char_valid_d;
   logic [CHAR_W-1:0] char_out_q, char_out_d;
   logic              finish_q, finish_d;

   logic              shift_en_s;
   logic [CHAR_W-1:0] shift_data_s;
   logic [CHAR_W-1:0] rd_data_s;

   lz77_hist_buf u_hist (
      .clk          (clk),
      .rst          (reset),
      .shift_en_i   (shift_en_s),
      .shift_data_i (shift_data_s),
      .rd_off_i     (off_q),
      .rd_data_o    (rd_data_s)
   );

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      lit_d        = lit_q;
      char_valid_d = 1'b0;
      char_out_d   = char_out_q;
      finish_d     = finish_q;
      shift_en_s   = 1'b0;
      shift_data_s = {CHAR_W{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (code_valid) begin
               off_d   = sat_offset(code_offset);
               len_d   = code_len;
               lit_d   = code_char;
               cnt_d   = {LEN_W{1'b0}};
               state_d = (code_len != {LEN_W{1'b0}}) ? ST_COPY : ST_LIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         // Read index stays fixed while the buffer shifts, so overlapping copies repeat the pattern.
         ST_COPY: begin
            char_out_d   = rd_data_s;
            char_valid_d = 1'b1;
            shift_en_s   = 1'b1;
            shift_data_s = rd_data_s;
            cnt_d        = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
               state_d = ST_LIT;
            end else begin
               state_d = ST_COPY;
            end
         end
         ST_LIT: begin
            if (lit_q == END_CHAR) begin
               finish_d = 1'b1;
               state_d  = ST_DONE;
            end else begin
               char_out_d   = lit_q;
               char_valid_d = 1'b1;
               shift_en_s   = 1'b1;
               shift_data_s = lit_q;
               state_d      = ST_IDLE;
            end
         end
         ST_DONE: begin
            finish_d = 1'b1;
            state_d  = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         off_q        <= {OFF_W{1'b0}};
         len_q        <= {LEN_W{1'b0}};
         cnt_q        <= {LEN_W{1'b0}};
         lit_q        <= {CHAR_W{1'b0}};
         char_valid_q <= 1'b0;
         char_out_q   <= {CHAR_W{1'b0}};
         finish_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         lit_q        <= lit_d;
         char_valid_q <= char_valid_d;
         char_out_q   <= char_out_d;
         finish_q     <= finish_d;
      end
   end

   assign code_ready = (state_q == ST_IDLE);
   assign char_valid = char_valid_q;
   assign char_out   = char_out_q;
   assign finish     = finish_q;
   assign encode     = 1'b0;

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed and random bench for lz77_decoder against a queue-based LZ77 reference model.
module tb_lz77_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       code_valid = 1'b0;
   logic       code_ready;
   logic [3:0] code_offset = 4'd0;
   logic [2:0] code_len = 3'd0;
   logic [7:0] code_char = 8'd0;
   logic       char_valid;
   logic [7:0] char_out;
   logic       finish;
   logic       encode;

   int total = 0;
   int bad   = 0;

   // Reference history: the whole decoded stream, preceded by nine '$' fill chars.
   logic [7:0] hist_m[$];

   lz77_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .code_valid  (code_valid),
      .code_ready  (code_ready),
      .code_offset (code_offset),
      .code_len    (code_len),
      .code_char   (code_char),
      .char_valid  (char_valid),
      .char_out    (char_out),
      .finish      (finish),
      .encode      (encode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist_m.delete();
      repeat (9) hist_m.push_back(8'h24);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      code_valid = 1'b0;
      #1;
      check("rst_ready", code_ready, 1);
      check("rst_valid", char_valid, 0);
      check("rst_finish", finish, 0);
      check("rst_char", char_out, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Drives one triplet and checks every char it produces, cycle by cycle.
   task automatic send(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch);
      logic [7:0] exp[$];
      logic [7:0] c;
      int         off_eff;
      int         waited;
      bit         is_end;
      off_eff = (off > 4'd8) ? 8 : int'(off);
      for (int k = 0; k < int'(len); k++) begin
         c = hist_m[hist_m.size() - 1 - off_eff];
         exp.push_back(c);
         hist_m.push_back(c);
      end
      is_end = (ch == 8'h24);
      if (!is_end) begin
         exp.push_back(ch);
         hist_m.push_back(ch);
      end
      waited = 0;
      while (code_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_accept", code_ready, 1);
      code_valid  = 1'b1;
      code_offset = off;
      code_len    = len;
      code_char   = ch;
      @(negedge clk);
      code_valid  = $urandom_range(0, 1);
      code_offset = 4'($urandom);
      code_len    = 3'($urandom);
      code_char   = 8'($urandom);
      check("ready_busy", code_ready, 0);
      check("no_early_valid", char_valid, 0);
      foreach (exp[i]) begin
         @(negedge clk);
         code_valid = 1'b0;
         check("char_valid", char_valid, 1);
         check("char_out", char_out, exp[i]);
      end
      if (is_end) begin
         @(negedge clk);
         code_valid = 1'b0;
         check("end_valid", char_valid, 0);
         check("end_finish", finish, 1);
         check("end_ready", code_ready, 0);
      end else begin
         code_valid = 1'b0;
         check("ready_after", code_ready, 1);
         check("finish_low", finish, 0);
      end
   endtask

   initial begin
      logic [7:0] rc;
      model_reset();
      #1;
      check("por_ready", code_ready, 1);
      check("por_valid", char_valid, 0);
      check("por_finish", finish, 0);
      check("encode_zero", encode, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset pulse in the middle of a copy, then decode from an all-'$' history.
      code_valid = 1'b1; code_offset = 4'd0; code_len = 3'd5; code_char = 8'h4B;
      @(negedge clk);
      code_valid = 1'b0;
      @(negedge clk);
      pulse_reset();
      send(4'd0, 3'd3, 8'h5A);

      // Back-to-back literals, then a non-overlapping match.
      pulse_reset();
      send(4'd0, 3'd0, 8'h41);
      send(4'd0, 3'd0, 8'h42);
      send(4'd1, 3'd2, 8'h43);
      check("abab_len", hist_m.size(), 14);

      // Overlapping copy of a single char.
      pulse_reset();
      send(4'd0, 3'd0, 8'h41);
      send(4'd0, 3'd5, 8'h58);

      // Offset 15 must read the same entry as offset 8.
      pulse_reset();
      for (int i = 0; i < 9; i++) send(4'd0, 3'd0, 8'h61 + 8'(i));
      send(4'd15, 3'd2, 8'h6D);
      send(4'd8, 3'd3, 8'h6E);

      // End of stream: one copied char, then finish and inputs ignored.
      pulse_reset();
      send(4'd0, 3'd0, 8'h58);
      send(4'd0, 3'd0, 8'h59);
      send(4'd0, 3'd0, 8'h5A);
      send(4'd2, 3'd1, 8'h24);
      code_valid = 1'b1; code_offset = 4'd0; code_len = 3'd3; code_char = 8'h57;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("done_valid", char_valid, 0);
         check("done_ready", code_ready, 0);
         check("done_finish", finish, 1);
      end
      code_valid = 1'b0;

      // Reset during a long copy aborts it and restores the history.
      pulse_reset();
      send(4'd0, 3'd0, 8'h31);
      code_valid = 1'b1; code_offset = 4'd0; code_len = 3'd7; code_char = 8'h51;
      @(negedge clk);
      code_valid = 1'b0;
      repeat (3) @(negedge clk);
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_valid", char_valid, 0);
         check("abort_finish", finish, 0);
      end
      send(4'd0, 3'd1, 8'h52);

      // Random triplets against the reference model, closed by '$'.
      pulse_reset();
      for (int i = 0; i < 60; i++) begin
         rc = 8'($urandom_range(0, 255));
         if (rc == 8'h24) rc = 8'h25;
         send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rc);
      end
      send(4'($urandom_range(0, 8)), 3'($urandom_range(0, 7)), 8'h24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
